// File: rtl/pulse_generator.sv
// pulse_generator: synthetic heartbeat source. Emits a pulse train at a
// programmed period with optional contact-bounce glitches after each rising
// edge, plus a one-cycle beat strobe and a wrapping beat counter.
module pulse_generator #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 1000,
    parameter int PERIOD_W    = 12,
    parameter int HIGH_TICKS  = 100,
    parameter int BOUNCE_N    = 3,
    parameter int BOUNCE_CYC  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enb,
    input  logic [PERIOD_W-1:0] period_ms,
    input  logic                bounce_en,
    output logic                pulse_out,
    output logic                beat,
    output logic [7:0]          beat_cnt
);

    localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
    localparam int PS_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BPH_N = (BOUNCE_N > 0) ? 2 * BOUNCE_N : 2;
    localparam int BPH_W = $clog2(BPH_N);
    localparam int BC_W  = (BOUNCE_CYC > 1) ? $clog2(BOUNCE_CYC) : 1;

    localparam logic [PS_W-1:0]     PS_LAST   = PS_W'(DIV - 1);
    localparam logic [BPH_W-1:0]    BPH_LAST  = BPH_W'(BPH_N - 1);
    localparam logic [BC_W-1:0]     BC_LAST   = BC_W'(BOUNCE_CYC - 1);
    localparam logic [PERIOD_W-1:0] HIGH_CNT  = PERIOD_W'(HIGH_TICKS);
    localparam logic [PERIOD_W-1:0] MIN_PER   = PERIOD_W'(HIGH_TICKS + 1);
    localparam bit                  BOUNCE_ON = (BOUNCE_N > 0);

    // Parameter sanity: integer divider, bounce finished before the first
    // tick, and the clamped period representable in PERIOD_W bits.
    generate
        if ((CLK_FREQ_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
            $error("pulse_generator: CLK_FREQ_HZ/TICK_HZ must be an integer >= 2");
        end
        if (2 * BOUNCE_N * BOUNCE_CYC >= DIV || BOUNCE_CYC < 1) begin : g_bad_bounce
            $error("pulse_generator: bounce burst must end before the first tick");
        end
        if (HIGH_TICKS < 1 || HIGH_TICKS >= (2 ** PERIOD_W) - 1) begin : g_bad_high
            $error("pulse_generator: HIGH_TICKS out of range for PERIOD_W");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BOUNCE,
        S_HIGH,
        S_LOW
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [PS_W-1:0]     r_presc;
    logic [PS_W-1:0]     w_presc_next;
    logic [PERIOD_W-1:0] r_tick_cnt;
    logic [PERIOD_W-1:0] w_tick_cnt_next;
    logic [PERIOD_W-1:0] w_tick_inc;
    logic [PERIOD_W-1:0] r_per;
    logic [BC_W-1:0]     r_bclk;
    logic [BC_W-1:0]     w_bclk_next;
    logic [BPH_W-1:0]    r_bph;
    logic [BPH_W-1:0]    w_bph_next;
    logic                w_tick;
    logic                w_pulse_next;
    logic                r_pulse;
    logic                r_beat;
    logic [7:0]          r_beat_cnt;

    // Tick fires on the last clock of each DIV-clock slot of the period.
    assign w_tick     = (r_presc == PS_LAST);
    assign w_tick_inc = r_tick_cnt + PERIOD_W'(1);

    assign pulse_out = r_pulse;
    assign beat      = r_beat;
    assign beat_cnt  = r_beat_cnt;

    // Next-state logic; enb low overrides every transition, including LOW exit.
    always_comb begin
        w_state_next = r_state;
        w_bclk_next  = r_bclk;
        w_bph_next   = r_bph;
        if (!enb) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (period_ms != '0) w_state_next = S_START;
                end
                S_START: begin
                    if (bounce_en && BOUNCE_ON) begin
                        w_state_next = S_BOUNCE;
                        w_bclk_next  = '0;
                        w_bph_next   = '0;
                    end else begin
                        w_state_next = S_HIGH;
                    end
                end
                S_BOUNCE: begin
                    if (r_bclk == BC_LAST) begin
                        w_bclk_next = '0;
                        if (r_bph == BPH_LAST) w_state_next = S_HIGH;
                        else                   w_bph_next   = r_bph + BPH_W'(1);
                    end else begin
                        w_bclk_next = r_bclk + BC_W'(1);
                    end
                end
                S_HIGH: begin
                    if (w_tick && (w_tick_inc == HIGH_CNT)) w_state_next = S_LOW;
                end
                S_LOW: begin
                    if (w_tick && (w_tick_inc == r_per)) begin
                        w_state_next = (period_ms != '0) ? S_START : S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Time base restarts on every START and is held clear while idle;
    // pulse level is decided from the upcoming state so the output is a flop.
    always_comb begin
        w_presc_next    = '0;
        w_tick_cnt_next = '0;
        w_pulse_next    = 1'b0;
        if (w_state_next != S_IDLE && w_state_next != S_START) begin
            w_presc_next    = w_tick ? '0 : r_presc + PS_W'(1);
            w_tick_cnt_next = w_tick ? w_tick_inc : r_tick_cnt;
        end
        case (w_state_next)
            S_START, S_HIGH: w_pulse_next = 1'b1;
            S_BOUNCE:        w_pulse_next = w_bph_next[0];
            default:         w_pulse_next = 1'b0;
        endcase
    end

    // State, time base and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_tick_cnt <= '0;
            r_bclk     <= '0;
            r_bph      <= '0;
            r_pulse    <= 1'b0;
            r_beat     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_presc    <= w_presc_next;
            r_tick_cnt <= w_tick_cnt_next;
            r_bclk     <= w_bclk_next;
            r_bph      <= w_bph_next;
            r_pulse    <= w_pulse_next;
            r_beat     <= (w_state_next == S_START);
        end
    end

    // Period latch and beat counter update at the end of each START cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_per      <= MIN_PER;
            r_beat_cnt <= '0;
        end else if (r_state == S_START) begin
            r_per      <= (period_ms > HIGH_CNT) ? period_ms : MIN_PER;
            r_beat_cnt <= r_beat_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_pulse_generator.sv
// tb_pulse_generator: randomized stimulus against a beat-offset reference
// model; expected per-cycle outputs go into a queue that an independent
// monitor drains and compares on the falling clock edge.
module tb_pulse_generator;

    localparam int DIV        = 10;
    localparam int HIGH_TICKS = 2;
    localparam int BOUNCE_N   = 2;
    localparam int BOUNCE_CYC = 1;
    localparam int PERIOD_W   = 12;

    logic                clk = 1'b0;
    logic                rst;
    logic                enb;
    logic [PERIOD_W-1:0] period_ms;
    logic                bounce_en;
    logic                pulse_out;
    logic                beat;
    logic [7:0]          beat_cnt;

    pulse_generator #(
        .CLK_FREQ_HZ(100),
        .TICK_HZ    (10),
        .PERIOD_W   (PERIOD_W),
        .HIGH_TICKS (HIGH_TICKS),
        .BOUNCE_N   (BOUNCE_N),
        .BOUNCE_CYC (BOUNCE_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .period_ms (period_ms),
        .bounce_en (bounce_en),
        .pulse_out (pulse_out),
        .beat      (beat),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pulse;
        logic       beat;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Reference model state: position inside the current beat.
    bit m_active = 1'b0;
    int m_off    = 0;
    int m_per    = HIGH_TICKS + 1;
    bit m_bounce = 1'b0;
    int m_cnt    = 0;

    // Expected pulse level at a given clock offset inside a beat.
    function automatic logic wave(input int off, input bit bnc);
        if (off == 0) return 1'b1;
        if (bnc && off <= 2 * BOUNCE_N * BOUNCE_CYC)
            return (((off - 1) / BOUNCE_CYC) % 2) == 1;
        return off < HIGH_TICKS * DIV;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: advances once per rising edge and queues the
    // outputs expected for the cycle that follows.
    initial forever begin
        exp_t e;
        @(posedge clk);
        if (!rst) begin
            m_active = 1'b0;
            m_off    = 0;
            m_cnt    = 0;
            exp_q.push_back('0);
        end else begin
            if (m_active && m_off == 0) begin
                m_cnt    = (m_cnt + 1) % 256;
                m_per    = (int'(period_ms) > HIGH_TICKS) ? int'(period_ms) : HIGH_TICKS + 1;
                m_bounce = bounce_en;
            end
            if (!enb) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                if (period_ms != 0) begin
                    m_active = 1'b1;
                    m_off    = 0;
                end
            end else if (m_off + 1 == m_per * DIV) begin
                if (period_ms != 0) m_off = 0;
                else                m_active = 1'b0;
            end else begin
                m_off++;
            end
            e.pulse = m_active ? wave(m_off, m_bounce) : 1'b0;
            e.beat  = m_active && (m_off == 0);
            e.cnt   = 8'(m_cnt);
            exp_q.push_back(e);
        end
    end

    // Asynchronous reset clears outputs within the current cycle, so the
    // expectation already queued for this cycle becomes the reset value.
    initial forever begin
        @(negedge rst);
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = '0;
    end

    // Monitor: pops one expectation per cycle and compares all outputs.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_underflow cycle %0d: got empty queue expected one entry", cyc);
        end else begin
            e = exp_q.pop_front();
            check("pulse_out", {7'd0, pulse_out}, {7'd0, e.pulse});
            check("beat", {7'd0, beat}, {7'd0, e.beat});
            check("beat_cnt", beat_cnt, e.cnt);
            if (e.beat || beat === 1'b1)
                $display("beat txn: cycle %0d beat=%0b beat_cnt=%0d (model beat=%0b cnt=%0d)",
                         cyc, beat, beat_cnt, e.beat, e.cnt);
        end
    end

    // Leaves the driver 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1 unit after an edge: asserts reset mid-cycle, holds it, and
    // releases it mid-cycle with the generator disabled.
    task automatic pulse_reset();
        #2;
        rst = 1'b0;
        enb = 1'b0;
        step(3);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        int r;
        rst       = 1'b1;
        enb       = 1'b0;
        period_ms = '0;
        bounce_en = 1'b0;
        #2 rst = 1'b0;
        step(3);
        #2 rst = 1'b1;
        step(5);

        // Steady 5-tick period, then the same with bounce.
        enb = 1'b1; period_ms = 12'd5; bounce_en = 1'b0;
        step(160);
        bounce_en = 1'b1;
        step(110);

        // Fresh beat, then reset in the middle of the high window.
        enb = 1'b0;
        step(2);
        enb = 1'b1; bounce_en = 1'b0;
        step(11);
        pulse_reset();
        step(5);

        // Clamped short period, then silence.
        enb = 1'b1; period_ms = 12'd1;
        step(100);
        period_ms = 12'd0;
        step(100);

        // Period change during the high window of a beat.
        period_ms = 12'd5;
        step(11);
        period_ms = 12'd8;
        step(180);

        // Disable at cycle 10 of a fresh beat, then re-enable.
        enb = 1'b0;
        step(2);
        enb = 1'b1; period_ms = 12'd5;
        step(11);
        enb = 1'b0;
        step(4);
        enb = 1'b1;
        step(30);

        // Random input changes at random moments.
        for (int i = 0; i < 250; i++) begin
            step($urandom_range(1, 40));
            enb = ($urandom_range(0, 9) != 0);
            r   = $urandom_range(0, 9);
            period_ms = (r == 0) ? 12'd0 : 12'($urandom_range(1, 9));
            bounce_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) pulse_reset();
        end

        // Enough minimum-period beats to wrap the beat counter.
        enb = 1'b1; period_ms = 12'd3; bounce_en = 1'b1;
        step(260 * 30 + 50);

        step(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
